// File: rtl/mem_io_pkg.sv
// Shared definitions for the processor memory-bus responder: region codes,
// timer register offsets and timer control bit positions.
package mem_io_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned SW_W   = 9;

    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_SW  = 4'h2;
    localparam logic [3:0] REG_TMR = 4'h3;

    localparam logic [1:0] TMR_LOAD   = 2'd0;
    localparam logic [1:0] TMR_CTRL   = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_W    = 2;

endpackage

// File: rtl/mem_io_responder_if.sv
// Processor memory-bus signals: request from the processor, registered read data back.
interface mem_io_responder_if;
    import mem_io_pkg::*;

    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DOUT;
    logic              W;
    logic [DATA_W-1:0] DIN;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/resp_ram.sv
// Inferred single-port synchronous RAM; a write returns the written word on the same edge.
module resp_ram #(
    parameter  int unsigned WORDS = 128,
    localparam int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    logic [15:0] mem [WORDS];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata_q   <= wdata;
        end else begin
            rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_io_responder.sv
// Memory-bus responder: decodes RAM, LED register, synchronised switches and a
// down-count timer, returning read data one cycle after the request.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 128
) (
    input  logic               Clock,
    input  logic               Reset,
    mem_io_responder_if.slave  bus,
    input  logic [SW_W-1:0]    SW,
    output logic [SW_W-1:0]    LEDR,
    output logic               TIRQ
);
    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    logic [3:0]        region_c;
    logic [1:0]        tmr_off_c;
    logic              ram_we_c;
    logic [DATA_W-1:0] ram_rdata;

    logic [SW_W-1:0]   led_q, led_d;
    logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]   sw_sync_q, sw_sync_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              exp_q, exp_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              sel_ram_q, sel_ram_d;

    assign region_c  = bus.ADDR[15:12];
    assign tmr_off_c = bus.ADDR[1:0];
    // Gating with Reset keeps a write from landing while reset is held.
    assign ram_we_c  = bus.W && (region_c == REG_RAM) && !Reset;

    resp_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk   (Clock),
        .we    (ram_we_c),
        .addr  (bus.ADDR[RAM_AW-1:0]),
        .wdata (bus.DOUT),
        .rdata (ram_rdata)
    );

    // Register updates and read-data selection.
    always_comb begin
        led_d     = led_q;
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
        load_d    = load_q;
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        exp_d     = exp_q;
        din_d     = '0;
        sel_ram_d = (region_c == REG_RAM);

        // STATUS read clears first so a same-edge expiry below wins.
        if (!bus.W && region_c == REG_TMR && tmr_off_c == TMR_STATUS)
            exp_d = 1'b0;

        if (bus.W && region_c == REG_TMR && tmr_off_c == TMR_LOAD) begin
            load_d  = bus.DOUT;
            count_d = bus.DOUT;
        end else if (ctrl_q[CTRL_EN]) begin
            if (count_q > 16'd1) begin
                count_d = count_q - 16'd1;
            end else if (count_q == 16'd1) begin
                exp_d = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = load_q;
                end else begin
                    count_d         = '0;
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        end

        if (bus.W && region_c == REG_TMR && tmr_off_c == TMR_CTRL)
            ctrl_d = bus.DOUT[CTRL_W-1:0];
        if (bus.W && region_c == REG_LED)
            led_d = bus.DOUT[SW_W-1:0];

        case (region_c)
            REG_LED: din_d = bus.W ? 16'(bus.DOUT[SW_W-1:0]) : 16'(led_q);
            REG_SW:  din_d = bus.W ? 16'd0 : 16'(sw_sync_q);
            REG_TMR: begin
                case (tmr_off_c)
                    TMR_LOAD:  din_d = bus.W ? bus.DOUT : load_q;
                    TMR_CTRL:  din_d = bus.W ? 16'(bus.DOUT[CTRL_W-1:0]) : 16'(ctrl_q);
                    TMR_COUNT: din_d = bus.W ? 16'd0 : count_q;
                    default:   din_d = bus.W ? 16'd0 : 16'(exp_q);
                endcase
            end
            default: din_d = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            load_q    <= '0;
            ctrl_q    <= '0;
            count_q   <= '0;
            exp_q     <= 1'b0;
            din_q     <= '0;
            sel_ram_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            load_q    <= load_d;
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            exp_q     <= exp_d;
            din_q     <= din_d;
            sel_ram_q <= sel_ram_d;
        end
    end

    // RAM data is already registered inside resp_ram; only the select is muxed here.
    assign bus.DIN = sel_ram_q ? ram_rdata : din_q;
    assign LEDR    = led_q;
    assign TIRQ    = exp_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;
    import mem_io_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] sw  = 9'h000;
    logic [8:0] ledr;
    logic       tirq;

    int n_checks = 0;
    int n_pass   = 0;

    mem_io_responder_if bus ();

    mem_io_responder #(.RAM_WORDS(128)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.slave),
        .SW    (sw),
        .LEDR  (ledr),
        .TIRQ  (tirq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One bus cycle; returns #1 after the capturing edge so DIN shows the result.
    task automatic op(input logic [15:0] a, input logic [15:0] d, input logic w);
        bus.ADDR = a;
        bus.DOUT = d;
        bus.W    = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.ADDR = '0;
        bus.DOUT = '0;
        bus.W    = 1'b0;
        #12;
        check("rst_din",  bus.DIN,     16'h0000);
        check("rst_ledr", 16'(ledr),   16'h0000);
        check("rst_tirq", 16'(tirq),   16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // RAM write, read-after-write, aliasing
        op(16'h0005, 16'h1234, 1'b1); check("ram_wr_din",  bus.DIN, 16'h1234);
        op(16'h0005, 16'h0000, 1'b0); check("ram_rd",      bus.DIN, 16'h1234);
        op(16'h0085, 16'h0000, 1'b0); check("ram_alias",   bus.DIN, 16'h1234);
        op(16'h0006, 16'hBEEF, 1'b1); check("ram_wr2_din", bus.DIN, 16'hBEEF);
        op(16'h0006, 16'h0000, 1'b0); check("ram_rd2",     bus.DIN, 16'hBEEF);
        op(16'h0005, 16'h0000, 1'b0); check("ram_rd1_again", bus.DIN, 16'h1234);

        // LED register and unmapped region
        op(16'h1000, 16'h01FF, 1'b1); check("led_wr_din", bus.DIN, 16'h01FF);
        check("led_out", 16'(ledr), 16'h01FF);
        op(16'h1000, 16'h0000, 1'b0); check("led_rd", bus.DIN, 16'h01FF);
        op(16'h7ABC, 16'h0000, 1'b0); check("unmapped_rd", bus.DIN, 16'h0000);
        op(16'h7ABC, 16'h5555, 1'b1); check("unmapped_wr", bus.DIN, 16'h0000);
        op(16'h2000, 16'hFFFF, 1'b1); check("sw_wr", bus.DIN, 16'h0000);

        // Switch synchroniser latency
        sw = 9'h0A5;
        op(16'h2000, 16'h0000, 1'b0); check("sw_e1", bus.DIN, 16'h0000);
        op(16'h2000, 16'h0000, 1'b0); check("sw_e2", bus.DIN, 16'h0000);
        op(16'h2000, 16'h0000, 1'b0); check("sw_e3", bus.DIN, 16'h00A5);

        // One-shot timer
        op(16'h3000, 16'h0003, 1'b1); check("t1_load_wr", bus.DIN, 16'h0003);
        op(16'h3001, 16'h0001, 1'b1); check("t1_ctrl_wr", bus.DIN, 16'h0001);
        op(16'h3002, 16'h0000, 1'b0); check("t1_cnt3", bus.DIN, 16'h0003);
        op(16'h3002, 16'h0000, 1'b0); check("t1_cnt2", bus.DIN, 16'h0002);
        check("t1_tirq_lo", 16'(tirq), 16'h0000);
        op(16'h3002, 16'h0000, 1'b0); check("t1_cnt1", bus.DIN, 16'h0001);
        check("t1_tirq_hi", 16'(tirq), 16'h0001);
        op(16'h3002, 16'h0000, 1'b0); check("t1_cnt0", bus.DIN, 16'h0000);
        op(16'h3001, 16'h0000, 1'b0); check("t1_en_clr", bus.DIN, 16'h0000);
        check("t1_tirq_hold", 16'(tirq), 16'h0001);
        op(16'h3003, 16'h0000, 1'b0); check("t1_stat1", bus.DIN, 16'h0001);
        check("t1_tirq_clr", 16'(tirq), 16'h0000);
        op(16'h3003, 16'h0000, 1'b0); check("t1_stat0", bus.DIN, 16'h0000);
        op(16'h3000, 16'h0000, 1'b0); check("t1_load_rd", bus.DIN, 16'h0003);

        // Auto-reload timer, STATUS read colliding with expiry
        op(16'h3000, 16'h0002, 1'b1); check("t2_load_wr", bus.DIN, 16'h0002);
        op(16'h3001, 16'h0003, 1'b1); check("t2_ctrl_wr", bus.DIN, 16'h0003);
        op(16'h3002, 16'h0000, 1'b0); check("t2_cnt2", bus.DIN, 16'h0002);
        op(16'h3002, 16'h0000, 1'b0); check("t2_cnt1", bus.DIN, 16'h0001);
        check("t2_tirq_p1", 16'(tirq), 16'h0001);
        op(16'h3003, 16'h0000, 1'b0); check("t2_stat_p1", bus.DIN, 16'h0001);
        check("t2_tirq_clr", 16'(tirq), 16'h0000);
        op(16'h3003, 16'h0000, 1'b0); check("t2_stat_collide", bus.DIN, 16'h0000);
        check("t2_tirq_set_wins", 16'(tirq), 16'h0001);
        op(16'h3002, 16'h0000, 1'b0); check("t2_cnt_reload", bus.DIN, 16'h0002);

        // Asynchronous reset mid-run; a write held during reset must not land
        #2;
        rst = 1'b1;
        #1;
        check("arst_din",  bus.DIN,   16'h0000);
        check("arst_ledr", 16'(ledr), 16'h0000);
        check("arst_tirq", 16'(tirq), 16'h0000);
        bus.ADDR = 16'h0005;
        bus.DOUT = 16'hDEAD;
        bus.W    = 1'b1;
        @(posedge clk);
        #1;
        bus.W = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        op(16'h0005, 16'h0000, 1'b0); check("ram_survives", bus.DIN, 16'h1234);
        op(16'h3002, 16'h0000, 1'b0); check("post_rst_cnt",  bus.DIN, 16'h0000);
        op(16'h3001, 16'h0000, 1'b0); check("post_rst_ctrl", bus.DIN, 16'h0000);
        op(16'h3000, 16'h0000, 1'b0); check("post_rst_load", bus.DIN, 16'h0000);
        op(16'h1000, 16'h0000, 1'b0); check("post_rst_led",  bus.DIN, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
